// File: rtl/product_unloader64_if.sv
`default_nettype none
// ============================================================================
//  Module      : product_unloader64_if
//  Description : Bundle for the product unloader. It carries the load
//                channel (one product word per handshake) and the beat
//                channel (fixed-width beats toward the consumer).
//  Ports       : none; the bundle is parameterised by DATA_W and BEAT_W.
//                Signals:
//                  in_valid / in_ready / in_data            load channel
//                  out_valid / out_ready / out_data / out_last  beat channel
//  Modports    : slave  - the unloader side
//                master - the surrounding logic (product register and
//                         downstream consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface product_unloader64_if #(
    parameter int DATA_W = 64,
    parameter int BEAT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/product_unloader64.sv
`default_nettype none
// ============================================================================
//  Module      : product_unloader64
//  Description : Reader side of the product register. It accepts one
//                DATA_W-bit word per load handshake and emits it as
//                DATA_W/BEAT_W beats over a valid/ready channel. By default
//                the low beat goes first. A load can coincide with the final
//                beat, so back-to-back words need no idle cycle.
//  Ports       : clk       rising-edge clock
//                reset_n   asynchronous active-low reset
//                bus       load and beat channels (slave modport)
//                abort     synchronous flush of the word in flight
//                busy      a word is in flight
//                done      one-cycle pulse after the final beat handshake
//                beat_idx  index of the beat currently presented
//  Revision    : 1.0 - initial release
// ============================================================================
module product_unloader64 #(
    parameter int DATA_W    = 64,
    parameter int BEAT_W    = 32,      // DATA_W must be a multiple of BEAT_W
    parameter int MSB_FIRST = 0,
    localparam int NBEATS   = DATA_W / BEAT_W,
    localparam int IDX_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  wire                 clk,
    input  wire                 reset_n,
    product_unloader64_if.slave bus,
    input  wire                 abort,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    beat_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                done_q,  done_d;

    logic [DATA_W-1:0]   shreg_shifted;
    logic                last_beat;
    logic                beat_hs;
    logic                load;

    // The beat on the wire always sits at one end of the shift register.
    // After each handshake the register moves the next beat into that slot.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign bus.out_data  = shreg_q[DATA_W-1 -: BEAT_W];
            assign shreg_shifted = shreg_q << BEAT_W;
        end else begin : g_lsb_first
            assign bus.out_data  = shreg_q[BEAT_W-1:0];
            assign shreg_shifted = shreg_q >> BEAT_W;
        end
    endgenerate

    assign busy          = (state_q == ST_SEND);
    assign bus.out_valid = busy;
    assign last_beat     = busy && (idx_q == LAST_IDX);
    assign bus.out_last  = last_beat;
    assign beat_idx      = idx_q;
    assign done          = done_q;
    assign beat_hs       = busy && bus.out_ready;

    // While the final beat is being accepted, the next word can load in the
    // same cycle. This path is combinational from out_ready. It never
    // depends on in_valid.
    assign bus.in_ready  = (state_q == ST_IDLE) ||
                           (last_beat && bus.out_ready && !abort);

    // In IDLE, in_ready stays high during abort, so abort must also gate
    // the capture here.
    assign load          = bus.in_valid && bus.in_ready && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        if (abort) begin
            // The shift register contents are left as they are. They are
            // don't-care until the next load.
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            if (beat_hs) begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    shreg_d = shreg_shifted;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            // A load overrides the final-beat return to IDLE.
            if (load) begin
                shreg_d = bus.in_data;
                idx_d   = '0;
                state_d = ST_SEND;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_unloader64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_unloader64
//  Description : Self-checking bench for product_unloader64. It drives two
//                instances with identical stimulus: one sends the LSB beat
//                first, the other sends the MSB beat first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_product_unloader64;

    localparam int NB = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    product_unloader64_if #(.DATA_W(64), .BEAT_W(32)) u_bus_l ();
    product_unloader64_if #(.DATA_W(64), .BEAT_W(32)) u_bus_m ();

    logic       busy_l, done_l, busy_m, done_m;
    logic [0:0] idx_l, idx_m;

    product_unloader64 #(.DATA_W(64), .BEAT_W(32), .MSB_FIRST(0)) u_dut_l (
        .clk(clk), .reset_n(reset_n), .bus(u_bus_l.slave), .abort(abort),
        .busy(busy_l), .done(done_l), .beat_idx(idx_l)
    );

    product_unloader64 #(.DATA_W(64), .BEAT_W(32), .MSB_FIRST(1)) u_dut_m (
        .clk(clk), .reset_n(reset_n), .bus(u_bus_m.slave), .abort(abort),
        .busy(busy_m), .done(done_m), .beat_idx(idx_m)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [63:0] d, input bit ordy, input bit ab);
        u_bus_l.in_valid  = iv;   u_bus_m.in_valid  = iv;
        u_bus_l.in_data   = d;    u_bus_m.in_data   = d;
        u_bus_l.out_ready = ordy; u_bus_m.out_ready = ordy;
        abort             = ab;
    endtask

    typedef struct {
        bit          iv;
        logic [63:0] d;
        bit          ordy;
        bit          ab;
        bit          ov;
        logic [31:0] od;
        bit          last;
        bit          ir;
        bit          dn;
        bit          idx;
    } vec_t;

    function automatic vec_t mk(input bit iv, input logic [63:0] d, input bit ordy, input bit ab,
                                input bit ov, input logic [31:0] od, input bit last,
                                input bit ir, input bit dn, input bit idx);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.ab = ab;
        v.ov = ov; v.od = od; v.last = last; v.ir = ir; v.dn = dn; v.idx = idx;
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model: the word in flight and the number of beats still to send
    int          mleft;
    logic [63:0] mword;
    bit          mdone;

    initial begin : main
        logic [63:0] w;
        bit          iv, ordy, ab;
        logic [63:0] d;
        bit          e_ir, e_last, nd;
        logic [63:0] e_od_l, e_od_m;

        w = 64'h0123_4567_89AB_CDEF;
        // basic, out_ready=1
        tbl.push_back(mk(1, w, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h89AB_CDEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h0123_4567, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        // backpressure on beat 0
        tbl.push_back(mk(1, w, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 32'h89AB_CDEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 32'h89AB_CDEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 32'h89AB_CDEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h89AB_CDEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h0123_4567, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        // back-to-back A=1, B=FFFF_FFFF_0000_0002 with in_valid held
        tbl.push_back(mk(1, 64'h1, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'hFFFF_FFFF_0000_0002, 1, 0,  1, 32'h1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 64'hFFFF_FFFF_0000_0002, 1, 0,  1, 32'h0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'hFFFF_FFFF, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        // abort after beat 0, then abort blocking an IDLE load, then reload
        tbl.push_back(mk(1, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'hCCCC_DDDD, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  1, 32'hAAAA_BBBB, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h5, 1, 1,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h5, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 32'h0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1, 0));

        // ---------------- reset state ----------------
        drive(0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", u_bus_l.in_ready, 1);
        chk("rst_out_valid", u_bus_l.out_valid, 0);
        chk("rst_busy", busy_l, 0);
        chk("rst_done", done_l, 0);
        chk("rst_beat_idx", idx_l, 0);
        chk("rst_out_data", u_bus_l.out_data, 0);
        reset_n = 1'b1;

        // ---------------- directed table ----------------
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].ab);
            #2;
            chk($sformatf("v%0d_out_valid", i), u_bus_l.out_valid, tbl[i].ov);
            chk($sformatf("v%0d_busy", i), busy_l, tbl[i].ov);
            chk($sformatf("v%0d_in_ready", i), u_bus_l.in_ready, tbl[i].ir);
            chk($sformatf("v%0d_out_last", i), u_bus_l.out_last, tbl[i].last);
            chk($sformatf("v%0d_beat_idx", i), idx_l, tbl[i].idx);
            chk($sformatf("v%0d_done", i), done_l, tbl[i].dn);
            if (tbl[i].ov)
                chk($sformatf("v%0d_out_data", i), u_bus_l.out_data, tbl[i].od);
        end

        // ---------------- async reset during a stall ----------------
        @(negedge clk);
        drive(1, 64'h0123_4567_89AB_CDEF, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        chk("stall_out_valid", u_bus_l.out_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", u_bus_l.out_valid, 0);
        chk("arst_busy", busy_l, 0);
        chk("arst_in_ready", u_bus_l.in_ready, 1);
        chk("arst_beat_idx", idx_l, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("post_rst_in_ready", u_bus_l.in_ready, 1);
        chk("post_rst_beat_idx", idx_l, 0);
        chk("post_rst_out_valid", u_bus_l.out_valid, 0);

        // ---------------- MSB-first ordering ----------------
        @(negedge clk);
        drive(1, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);
        @(negedge clk);
        drive(0, 0, 1, 0);
        #2;
        chk("msb_beat0_data", u_bus_m.out_data, 32'hDEAD_BEEF);
        chk("msb_beat0_last", u_bus_m.out_last, 0);
        @(negedge clk);
        #2;
        chk("msb_beat1_data", u_bus_m.out_data, 32'hCAFE_F00D);
        chk("msb_beat1_last", u_bus_m.out_last, 1);
        @(negedge clk);
        #2;
        chk("msb_done", done_m, 1);
        chk("msb_idle", busy_m, 0);
        @(negedge clk);

        // ---------------- randomized against the model ----------------
        mleft = 0;
        mword = '0;
        mdone = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            iv   = bit'($urandom_range(0, 1));
            d    = {$urandom, $urandom};
            ordy = ($urandom_range(0, 3) != 0);
            ab   = ($urandom_range(0, 15) == 0);
            drive(iv, d, ordy, ab);

            e_ir   = (mleft == 0) || (ordy && mleft == 1 && !ab);
            e_last = (mleft == 1);
            e_od_l = mword >> (32 * (NB - mleft));
            e_od_m = mword >> (32 * (mleft - 1));
            #2;
            chk("rnd_in_ready", u_bus_l.in_ready, e_ir);
            chk("rnd_out_valid", u_bus_l.out_valid, mleft > 0);
            chk("rnd_busy", busy_l, mleft > 0);
            chk("rnd_out_last", u_bus_l.out_last, e_last);
            chk("rnd_done", done_l, mdone);
            chk("rnd_m_in_ready", u_bus_m.in_ready, e_ir);
            chk("rnd_m_out_last", u_bus_m.out_last, e_last);
            chk("rnd_m_done", done_m, mdone);
            if (mleft > 0) begin
                chk("rnd_beat_idx", idx_l, 64'(NB - mleft));
                chk("rnd_m_beat_idx", idx_m, 64'(NB - mleft));
                chk("rnd_out_data", u_bus_l.out_data, e_od_l[31:0]);
                chk("rnd_m_out_data", u_bus_m.out_data, e_od_m[31:0]);
            end

            @(posedge clk);
            if (ab) begin
                mleft = 0;
                mdone = 1'b0;
            end else begin
                nd = (mleft == 1) && ordy;
                if (mleft > 0 && ordy)
                    mleft = mleft - 1;
                if (iv && e_ir) begin
                    mword = d;
                    mleft = NB;
                end
                mdone = nd;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/product_unloader64.md
Name: product_unloader64

Overview:
Reader side of the 64-bit product register. Accepts one 64-bit product per handshake and streams it out as fixed-width beats over a valid/ready bus, low beat first by default. Sits between the Booth multiplier's product register and a narrower downstream consumer (bus bridge or 32-bit result port). Supports back-to-back products with no idle cycle when the final beat and the next load coincide.

Parameters:
DATA_W, 64, width of the loaded product word
BEAT_W, 32, output beat width; DATA_W must be an integer multiple of BEAT_W
MSB_FIRST, 0, 0 = least-significant beat first, 1 = most-significant beat first
NBEATS is derived as DATA_W/BEAT_W; it is not a parameter.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  product word available
in_ready  output  1  unloader can accept a product this cycle
in_data  input  DATA_W  product word
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
out_data  output  BEAT_W  current beat
out_last  output  1  current beat is the final beat of the word
abort  input  1  synchronous flush of the word in flight
busy  output  1  word in flight (state SEND)
done  output  1  one-cycle pulse, cycle after the final beat handshake
beat_idx  output  clog2(NBEATS) (min 1)  index of current beat

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, shift register=0, beat_idx=0, out_valid=0, done=0. in_ready follows the state (1 in IDLE), so it reads 1 while reset is held.
- States: IDLE, SEND. busy = (state==SEND). out_valid = busy.
- in_ready = (state==IDLE) OR (state==SEND AND out_ready AND out_last AND !abort). This is combinational from out_ready. No path runs from in_valid to in_ready.
- Load: when in_valid AND in_ready, capture in_data into the shift register, set beat_idx=0, and go to SEND.
- Beat order:
  - MSB_FIRST=0: out_data = shreg[BEAT_W-1:0]; on each beat handshake shift right by BEAT_W.
  - MSB_FIRST=1: out_data = shreg[DATA_W-1:DATA_W-BEAT_W]; shift left.
  - Vacated bits fill with 0.
- Beat handshake (out_valid AND out_ready):
  - beat_idx < NBEATS-1: shift, then beat_idx+1.
  - beat_idx == NBEATS-1 (out_last=1): next-cycle done=1. If a load happens in the same cycle, reload and stay in SEND with beat_idx=0. Otherwise go to IDLE.
- out_last = busy AND (beat_idx == NBEATS-1).
- Stall: while out_valid AND !out_ready, out_data, out_last and beat_idx hold stable. out_valid never deasserts without a handshake, except on abort or reset.
- abort (synchronous, highest priority after reset):
  - Next state is IDLE, beat_idx=0, out_valid=0 next cycle, no done pulse.
  - The shift register contents are don't-care.
  - in_ready is forced to 0 that cycle in SEND. In IDLE it stays 1, but abort blocks the load, so the capture is suppressed.
- done is registered, width 1 cycle, and is cleared by reset and by abort. Back-to-back words give one pulse per word.
- Reset mid-word: outputs return to reset values immediately. The partial word is lost.
- Latency: load at edge N gives first beat valid after edge N. A word takes NBEATS handshake cycles at minimum. Continuous throughput is 1 beat/cycle, with no bubble between words.
- NBEATS=1 (BEAT_W=DATA_W) is legal: each word is a single beat with out_last=1.

Test Plan:
- Basic, out_ready=1: reset, load 64'h0123_4567_89AB_CDEF -> beats 32'h89AB_CDEF (last=0), then 32'h0123_4567 (last=1), done pulse the next cycle, then IDLE with in_ready=1.
- Backpressure: same word, out_ready low for 3 cycles on beat 0 -> out_data holds 32'h89AB_CDEF, out_valid stays 1, beat_idx=0; release -> normal completion, exactly one done pulse.
- Back-to-back: in_valid held with words A=64'h1, B=64'hFFFF_FFFF_0000_0002, out_ready=1 -> beats 1, 0, 2, FFFF_FFFF with no gap cycle; in_ready=1 on A's last beat; two done pulses.
- MSB_FIRST=1, 64'hDEAD_BEEF_CAFE_F00D -> DEAD_BEEF then CAFE_F00D; out_last on the second beat.
- Abort after beat 0 of 64'hAAAA_BBBB_CCCC_DDDD -> out_valid=0 next cycle, no done pulse, IDLE; a new load of 64'h5 then yields beats 5, 0.
- Async reset asserted mid-stall (between edges) -> out_valid and busy drop immediately; after release in_ready=1 and beat_idx=0.
